// File: rtl/conv_peak_detect.sv
// Peak/energy detector for bursts of complex samples from the correlation stage.
// Optional energy accumulator enabled by macro CONV_PEAK_ENERGY_EN.
module conv_peak_detect (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [35:0] in_data,
  output logic        out_valid,
  output logic [35:0] peak_mag,
  output logic [2:0]  peak_idx,
  output logic [2:0]  burst_len,
  output logic [38:0] energy
);

  // state  | meaning
  // IDLE   | waiting for the first sample of a burst
  // ACC    | burst in progress, tracking peak/count
  // REPORT | result strobe; a sample here starts the next burst
  typedef enum logic [1:0] {IDLE, ACC, REPORT} state_t;

  localparam logic [2:0] MAX_LEN = 3'd7;

  state_t state_q, state_d;

  logic signed [17:0] re_s, im_s;
  logic signed [35:0] re_sq, im_sq;
  logic        [35:0] mag;

  logic [2:0]  cnt_q, cnt_d;
  logic [35:0] pk_mag_q, pk_mag_d;
  logic [2:0]  pk_idx_q, pk_idx_d;
  logic [35:0] rep_mag_q, rep_mag_d;
  logic [2:0]  rep_idx_q, rep_idx_d;
  logic [2:0]  rep_len_q, rep_len_d;
  logic [38:0] energy_src;

  logic accept_first, accept_more, close_burst;

  assign re_s  = in_data[35:18];
  assign im_s  = in_data[17:0];
  assign re_sq = re_s * re_s;
  assign im_sq = im_s * im_s;
  // Each square is at most 2^34, so the sum always fits in 36 unsigned bits.
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

  assign accept_first = in_valid && (state_q != ACC);
  assign accept_more  = in_valid && (state_q == ACC) && (cnt_q != MAX_LEN);
  assign close_burst  = !in_valid && (state_q == ACC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ACC;
      ACC:     if (!in_valid) state_d = REPORT;
      REPORT:  state_d = in_valid ? ACC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    pk_mag_d  = pk_mag_q;
    pk_idx_d  = pk_idx_q;
    rep_mag_d = rep_mag_q;
    rep_idx_d = rep_idx_q;
    rep_len_d = rep_len_q;
    if (accept_first) begin
      cnt_d    = 3'd1;
      pk_mag_d = mag;
      pk_idx_d = 3'd0;
    end else if (accept_more) begin
      cnt_d = cnt_q + 3'd1;
      // Strict compare keeps the earliest index on ties.
      if (mag > pk_mag_q) begin
        pk_mag_d = mag;
        pk_idx_d = cnt_q;
      end
    end
    if (close_burst) begin
      rep_mag_d = pk_mag_q;
      rep_idx_d = pk_idx_q;
      rep_len_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pk_mag_q  <= '0;
      pk_idx_q  <= '0;
      rep_mag_q <= '0;
      rep_idx_q <= '0;
      rep_len_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pk_mag_q  <= pk_mag_d;
      pk_idx_q  <= pk_idx_d;
      rep_mag_q <= rep_mag_d;
      rep_idx_q <= rep_idx_d;
      rep_len_q <= rep_len_d;
    end
  end

`ifdef CONV_PEAK_ENERGY_EN
  logic [38:0] en_acc_q, en_acc_d;
  logic [38:0] rep_en_q, rep_en_d;

  always_comb begin
    en_acc_d = en_acc_q;
    rep_en_d = rep_en_q;
    if (accept_first) begin
      en_acc_d = {3'b000, mag};
    end else if (accept_more) begin
      en_acc_d = en_acc_q + {3'b000, mag};
    end
    if (close_burst) begin
      rep_en_d = en_acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_acc_q <= '0;
      rep_en_q <= '0;
    end else begin
      en_acc_q <= en_acc_d;
      rep_en_q <= rep_en_d;
    end
  end

  assign energy_src = rep_en_q;
`else
  assign energy_src = '0;
`endif

  always_comb begin
    out_valid = (state_q == REPORT);
    peak_mag  = '0;
    peak_idx  = '0;
    burst_len = '0;
    energy    = '0;
    if (state_q == REPORT) begin
      peak_mag  = rep_mag_q;
      peak_idx  = rep_idx_q;
      burst_len = rep_len_q;
      energy    = energy_src;
    end
  end

endmodule

// File: tb/tb_conv_peak_detect.sv
// Self-checking bench for conv_peak_detect: burst-level reference model plus
// literal expectations for the directed scenarios.
module tb_conv_peak_detect;

`ifdef CONV_PEAK_ENERGY_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [35:0] in_data = '0;
  logic        out_valid;
  logic [35:0] peak_mag;
  logic [2:0]  peak_idx;
  logic [2:0]  burst_len;
  logic [38:0] energy;

  conv_peak_detect dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .peak_mag  (peak_mag),
    .peak_idx  (peak_idx),
    .burst_len (burst_len),
    .energy    (energy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit model_ready = 1'b0;

  int     q_re[$];
  int     q_im[$];
  bit     e_valid = 1'b0;
  longint e_mag = 0;
  longint e_en = 0;
  int     e_idx = 0;
  int     e_len = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: collect each burst, evaluate it when in_valid drops.
  always @(posedge clk) begin
    if (!rst_n) begin
      q_re.delete();
      q_im.delete();
      e_valid = 1'b0;
      e_mag = 0; e_en = 0; e_idx = 0; e_len = 0;
      model_ready = 1'b1;
    end else if (in_valid) begin
      q_re.push_back(int'($signed(in_data[35:18])));
      q_im.push_back(int'($signed(in_data[17:0])));
      e_valid = 1'b0;
      e_mag = 0; e_en = 0; e_idx = 0; e_len = 0;
    end else if (q_re.size() > 0) begin
      int n;
      longint best, sum, m;
      n = (q_re.size() > 7) ? 7 : q_re.size();
      best = -1; sum = 0; e_idx = 0;
      for (int i = 0; i < n; i++) begin
        m = longint'(q_re[i]) * q_re[i] + longint'(q_im[i]) * q_im[i];
        sum += m;
        if (m > best) begin
          best = m;
          e_idx = i;
        end
      end
      e_valid = 1'b1;
      e_mag = best;
      e_len = n;
      e_en = EN ? sum : 0;
      q_re.delete();
      q_im.delete();
    end else begin
      e_valid = 1'b0;
      e_mag = 0; e_en = 0; e_idx = 0; e_len = 0;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      chk("out_valid", 64'(out_valid), 64'(e_valid));
      chk("peak_mag", 64'(peak_mag), 64'(e_mag));
      chk("peak_idx", 64'(peak_idx), 64'(e_idx));
      chk("burst_len", 64'(burst_len), 64'(e_len));
      chk("energy", 64'(energy), 64'(e_en));
      if (out_valid === 1'b1) pulses++;
    end
  end

  task automatic drive(input bit v, input int re, input int im);
    @(negedge clk);
    in_valid = v;
    in_data  = {re[17:0], im[17:0]};
  endtask

  task automatic lit_pulse(input string name, input longint m, input int idx,
                           input int len, input longint en);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got = 1'b1;
        chk({name, "_mag"}, 64'(peak_mag), 64'(m));
        chk({name, "_idx"}, 64'(peak_idx), 64'(idx));
        chk({name, "_len"}, 64'(burst_len), 64'(len));
        chk({name, "_energy"}, 64'(energy), 64'(en));
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: out_valid got 0 for 4 cycles, required 1", name);
    end
  endtask

  task automatic burst5;
    drive(1, 3, 4);
    drive(1, 1, 1);
    drive(1, -6, 8);
    drive(1, 0, 2);
    drive(1, 5, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = {18'sd3, 18'sd4};
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_peak_mag", 64'(peak_mag), 64'd0);
    chk("rst_burst_len", 64'(burst_len), 64'd0);
    chk("rst_energy", 64'(energy), 64'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    drive(0, 0, 0);

    burst5();
    drive(0, 0, 0);
    lit_pulse("burst5", 100, 2, 5, EN ? 156 : 0);
    drive(0, 0, 0);

    drive(1, 3, 4);
    drive(1, -5, 0);
    drive(1, 0, -4);
    drive(0, 0, 0);
    lit_pulse("tie", 25, 0, 3, EN ? 66 : 0);
    drive(0, 0, 0);

    drive(1, -131072, -131072);
    drive(0, 0, 0);
    lit_pulse("extreme", 64'd34359738368, 0, 1, EN ? 64'd34359738368 : 0);
    drive(0, 0, 0);

    // B's only sample is presented during A's report cycle.
    burst5();
    drive(0, 0, 0);
    lit_pulse("b2b_A", 100, 2, 5, EN ? 156 : 0);
    in_valid = 1'b1;
    in_data = {18'sd7, 18'sd0};
    drive(0, 0, 0);
    lit_pulse("b2b_B", 49, 0, 1, EN ? 49 : 0);
    drive(0, 0, 0);

    for (int i = 0; i < 8; i++) drive(1, 1, 0);
    drive(1, 9, 9);
    drive(0, 0, 0);
    lit_pulse("overlen", 1, 0, 7, EN ? 7 : 0);
    drive(0, 0, 0);

    for (int k = 0; k < 7; k++) drive(1, k, 0);
    drive(0, 0, 0);
    lit_pulse("ascend7", 36, 6, 7, EN ? 91 : 0);
    drive(0, 0, 0);

    drive(1, 5, 5);
    drive(1, 2, 1);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = {18'sd9, 18'sd9};
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = {18'sd2, 18'sd2};
    drive(0, 0, 0);
    lit_pulse("rst_abort", 8, 0, 1, EN ? 8 : 0);

    repeat (3) drive(0, 0, 0);
    chk("pulse_count", 64'(pulses), 64'd8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
